avalon_bus_arbiter: RTL



---
 rtl/avalon_bus_arbiter_pkg.sv | 30 +++
 rtl/avalon_bus_arbiter_if.sv | 34 +++
 rtl/avalon_bus_arbiter_picker.sv | 31 +++
 rtl/avalon_bus_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared Avalon-MM request/response types and arbitration constants for the
// core-to-interconnect arbiter.
package avalon_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byte_enable;
    } avalon_req_t;

    typedef struct packed {
        logic              waitrequest;
        logic [DATA_W-1:0] readdata;
    } avalon_resp_t;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// Bundle of the per-master ports, the shared slave port and the grant debug
// outputs; "slave" is the arbiter's view, "master" the surrounding system's.
interface avalon_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int MID_WIDTH   = $clog2(NUM_MASTERS)
);
    import avalon_bus_arbiter_pkg::*;

    avalon_req_t  [NUM_MASTERS-1:0] m_avalon_req;
    avalon_resp_t [NUM_MASTERS-1:0] m_avalon_resp;
    avalon_req_t                    s_avalon_req;
    avalon_resp_t                   s_avalon_resp;
    logic         [MID_WIDTH-1:0]   grant_id;
    logic                           grant_valid;

    modport slave (
        input  m_avalon_req,
        input  s_avalon_resp,
        output m_avalon_resp,
        output s_avalon_req,
        output grant_id,
        output grant_valid
    );

    modport master (
        output m_avalon_req,
        output s_avalon_resp,
        input  m_avalon_resp,
        input  s_avalon_req,
        input  grant_id,
        input  grant_valid
    );

endinterface

// File: rtl/avalon_bus_arbiter_picker.sv
// Combinational requester picker: scans from a start index upward with wrap
// (round-robin) or from index 0 (fixed priority).
module arb_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             mode,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int base;
        int idx;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        base      = mode ? int'(start) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[IDX_W'(idx)]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM slave between NUM_MASTERS masters: combinational request
// path, selection locked across waitrequest, 1-cycle read data routed to its issuer.
module avalon_bus_arbiter
    import avalon_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = ARB_RR,
    parameter int MID_WIDTH   = $clog2(NUM_MASTERS)
) (
    input logic                  clk,
    input logic                  rst_n,
    avalon_bus_arbiter_if.slave  bus
);

    lock_state_t            lock_state;
    lock_state_t            lock_next;
    logic [MID_WIDTH-1:0]   locked_id;
    logic [MID_WIDTH-1:0]   rr_ptr;
    logic [MID_WIDTH-1:0]   rd_owner;
    logic                   rd_pending;

    logic [NUM_MASTERS-1:0] req;
    logic [MID_WIDTH-1:0]   pick_idx;
    logic                   pick_any;
    logic [MID_WIDTH-1:0]   sel;
    logic                   sel_valid;
    logic                   fire;
    avalon_req_t            sel_req;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = bus.m_avalon_req[i].read | bus.m_avalon_req[i].write;
        end
    end

    arb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (MID_WIDTH)
    ) u_picker (
        .req       (req),
        .start     (rr_ptr),
        .mode      (ARB_MODE == ARB_RR),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // A held lock overrides the picker so the slave-visible request stays
    // stable; the lock drops by itself if the owner withdraws its request.
    always_comb begin
        if (lock_state == LOCK_HELD) begin
            sel       = locked_id;
            sel_valid = req[locked_id] & rst_n;
        end else begin
            sel       = pick_idx;
            sel_valid = pick_any & rst_n;
        end
        sel_req   = bus.m_avalon_req[sel];
        fire      = sel_valid & ~bus.s_avalon_resp.waitrequest;
        lock_next = (sel_valid && bus.s_avalon_resp.waitrequest) ? LOCK_HELD : LOCK_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= LOCK_IDLE;
        end else begin
            lock_state <= lock_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_id  <= '0;
            rr_ptr     <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
        end else begin
            if (sel_valid && bus.s_avalon_resp.waitrequest) begin
                locked_id <= sel;
            end
            if (fire && (ARB_MODE == ARB_RR)) begin
                rr_ptr <= (sel == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
            end
            rd_pending <= fire & sel_req.read;
            if (fire && sel_req.read) begin
                rd_owner <= sel;
            end
        end
    end

    always_comb begin
        bus.s_avalon_req = '0;
        if (sel_valid) begin
            bus.s_avalon_req = sel_req;
        end
        bus.grant_valid = sel_valid;
        bus.grant_id    = sel;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_avalon_resp[i] = '0;
            // Losers stall; idle masters are never stalled so they may move freely.
            if (req[i]) begin
                bus.m_avalon_resp[i].waitrequest =
                    (sel_valid && sel == MID_WIDTH'(i)) ? bus.s_avalon_resp.waitrequest : 1'b1;
            end
            if (rd_pending && rd_owner == MID_WIDTH'(i)) begin
                bus.m_avalon_resp[i].readdata = bus.s_avalon_resp.readdata;
            end
        end
    end

endmodule
